// File: rtl/loop_nest_ctrl.sv
// Hardware loop stack: nested iteration counters with superscalar lane issue,
// auto-pop of exhausted loops and multi-level BREAK unwinding.
module loop_nest_ctrl #(
    parameter int BITS                  = 18,
    parameter int LOOP_LOG_CNT          = 3,
    parameter int SUPERSCALAR_LOG_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [BITS-1:0]                cmd_arg,
    input  logic                           cmd_independent,
    output logic [LOOP_LOG_CNT:0]          depth,
    output logic [BITS-1:0]                top_remaining,
    output logic                           top_independent,
    output logic [SUPERSCALAR_LOG_WIDTH:0] lanes,
    output logic                           last_iter,
    output logic                           loop_exit,
    output logic                           overflow_err,
    output logic                           underflow_err
);
    localparam int LOOP_CNT = 1 << LOOP_LOG_CNT;
    localparam int W        = 1 << SUPERSCALAR_LOG_WIDTH;

    localparam logic [1:0] OP_PUSH  = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_BREAK = 2'd3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_UNWIND = 1'b1;

    localparam logic [LOOP_LOG_CNT:0]          DEPTH_ONE  = 1;
    localparam logic [LOOP_LOG_CNT:0]          DEPTH_FULL = (LOOP_LOG_CNT+1)'(LOOP_CNT);
    localparam logic [BITS-1:0]                ARG_ONE    = 1;
    localparam logic [BITS-1:0]                W_B        = BITS'(W);
    localparam logic [SUPERSCALAR_LOG_WIDTH:0] LANES_ONE  = 1;
    localparam logic [SUPERSCALAR_LOG_WIDTH:0] LANES_W    = (SUPERSCALAR_LOG_WIDTH+1)'(W);

    logic [BITS-1:0]         cnt_q [LOOP_CNT];
    logic [BITS-1:0]         cnt_d [LOOP_CNT];
    logic                    ind_q [LOOP_CNT];
    logic                    ind_d [LOOP_CNT];
    logic [LOOP_LOG_CNT:0]   depth_q, depth_d;
    logic [0:0]              state_q, state_d;
    logic [BITS-1:0]         unwind_q, unwind_d;
    logic                    exit_q, exit_d;
    logic                    ovf_q, ovf_d;
    logic                    udf_q, udf_d;

    logic [LOOP_LOG_CNT-1:0] top_idx;
    logic [LOOP_LOG_CNT-1:0] push_idx;
    logic                    empty;
    logic [BITS-1:0]         lanes_ext;
    logic [BITS-1:0]         step_res;

    assign empty           = (depth_q == '0);
    assign top_idx         = LOOP_LOG_CNT'(depth_q - DEPTH_ONE);
    assign push_idx        = depth_q[LOOP_LOG_CNT-1:0];
    assign top_remaining   = empty ? '0 : cnt_q[top_idx];
    assign top_independent = empty ? 1'b0 : ind_q[top_idx];

    always_comb begin
        if (empty)                 lanes = '0;
        else if (!top_independent) lanes = LANES_ONE;
        else if (top_remaining < W_B)
            lanes = top_remaining[SUPERSCALAR_LOG_WIDTH:0];
        else                       lanes = LANES_W;
    end

    assign lanes_ext = BITS'(lanes);
    assign last_iter = !empty && (top_remaining <= lanes_ext);
    // Saturate at zero so a STEP can never wrap the counter.
    assign step_res  = (top_remaining > lanes_ext) ? top_remaining - lanes_ext : '0;

    assign depth         = depth_q;
    assign cmd_ready     = (state_q == ST_IDLE);
    assign loop_exit     = exit_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path infers a latch.
        cnt_d    = cnt_q;
        ind_d    = ind_q;
        depth_d  = depth_q;
        state_d  = state_q;
        unwind_d = unwind_q;
        exit_d   = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (cmd_arg == '0) begin
                                exit_d = 1'b1;
                            end else if (depth_q == DEPTH_FULL) begin
                                ovf_d = 1'b1;
                            end else begin
                                cnt_d[push_idx] = cmd_arg;
                                ind_d[push_idx] = cmd_independent;
                                depth_d         = depth_q + DEPTH_ONE;
                            end
                        end
                        OP_STEP: begin
                            if (empty) begin
                                udf_d = 1'b1;
                            end else if (step_res == '0) begin
                                cnt_d[top_idx] = '0;
                                ind_d[top_idx] = 1'b0;
                                depth_d        = depth_q - DEPTH_ONE;
                                exit_d         = 1'b1;
                            end else begin
                                cnt_d[top_idx] = step_res;
                            end
                        end
                        OP_BREAK: begin
                            if (cmd_arg != '0) begin
                                if (empty) begin
                                    udf_d = 1'b1;
                                end else begin
                                    cnt_d[top_idx] = '0;
                                    ind_d[top_idx] = 1'b0;
                                    depth_d        = depth_q - DEPTH_ONE;
                                    exit_d         = 1'b1;
                                    unwind_d       = cmd_arg - ARG_ONE;
                                    // More levels requested than remain after this pop.
                                    if (unwind_d != '0) begin
                                        if (depth_q == DEPTH_ONE) udf_d   = 1'b1;
                                        else                      state_d = ST_UNWIND;
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_UNWIND: begin
                cnt_d[top_idx] = '0;
                ind_d[top_idx] = 1'b0;
                depth_d        = depth_q - DEPTH_ONE;
                exit_d         = 1'b1;
                unwind_d       = unwind_q - ARG_ONE;
                if (depth_q == DEPTH_ONE) begin
                    state_d = ST_IDLE;
                    if (unwind_d != '0) udf_d = 1'b1;
                end else if (unwind_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the stack storage is reset because entries above depth must read zero.
            for (int i = 0; i < LOOP_CNT; i++) begin
                cnt_q[i] <= '0;
                ind_q[i] <= 1'b0;
            end
            depth_q  <= '0;
            state_q  <= ST_IDLE;
            unwind_q <= '0;
            exit_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            cnt_q    <= cnt_d;
            ind_q    <= ind_d;
            depth_q  <= depth_d;
            state_q  <= state_d;
            unwind_q <= unwind_d;
            exit_q   <= exit_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end
endmodule

// File: doc/loop_nest_ctrl.md
Name: loop_nest_ctrl

Overview:
- Parametrised successor to the single-level loop counters: a hardware loop stack for the control unit.
- Holds up to 2^LOOP_LOG_CNT nested loops.
- Issues per-step lane counts for superscalar independent loops and auto-pops exhausted loops.
- Supports multi-level BREAK unwinding, with a valid/ready command handshake and sticky error flags. Sits between instruction decode and the APU loop-variable logic.

Parameters:
BITS, 18, iteration counter width
LOOP_LOG_CNT, 3, log2 of stack depth (LOOP_CNT = 1<<LOOP_LOG_CNT)
SUPERSCALAR_LOG_WIDTH, 2, log2 of max lanes per step (W = 1<<SUPERSCALAR_LOG_WIDTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  0 NOP, 1 PUSH, 2 STEP, 3 BREAK
cmd_arg  in  BITS  PUSH: iteration count; BREAK: levels to unwind
cmd_independent  in  1  PUSH: loop body is lane-independent
depth  out  LOOP_LOG_CNT+1  live loops (0..LOOP_CNT)
top_remaining  out  BITS  iterations left in top loop (0 when empty)
top_independent  out  1  top loop independent flag (0 when empty)
lanes  out  SUPERSCALAR_LOG_WIDTH+1  iterations the next STEP consumes (0 when empty)
last_iter  out  1  next STEP exhausts the top loop
loop_exit  out  1  one-cycle pulse: a loop was popped or a zero-count PUSH was skipped
overflow_err  out  1  sticky: PUSH while full
underflow_err  out  1  sticky: STEP/BREAK with insufficient depth

Behaviour:
- Reset (async assert, sync deassert to clk):
  - depth=0, all stack entries cleared, state IDLE, cmd_ready=1.
  - loop_exit=0, both error flags=0.
  - Reset mid-UNWIND aborts the unwind.
- Combinational outputs:
  - lanes = independent ? min(top_remaining, W) : 1, or 0 if depth==0.
  - last_iter = depth!=0 && top_remaining<=lanes.
- Entry stores the remaining count directly (not count-1). Arithmetic is unsigned BITS wide and never wraps below 0.
- State IDLE, cmd_ready=1. On an accepted command, effects are visible the next cycle:
  - PUSH, depth<LOOP_CNT, arg!=0: write entry[depth]={arg, independent}; depth+1.
  - PUSH, arg==0: stack unchanged; loop_exit pulses.
  - PUSH, depth==LOOP_CNT: ignored; overflow_err<=1.
  - STEP, depth>0: top_remaining -= lanes.
    - If the result is 0: pop (depth-1) in the same edge and pulse loop_exit.
  - STEP, depth==0: ignored; underflow_err<=1.
  - BREAK, arg==0: NOP.
  - BREAK, arg>0, depth>0: pop one level this edge and pulse loop_exit. Load unwind counter = arg-1.
    - If the counter is nonzero and depth-1>0, go to UNWIND.
  - BREAK, depth==0: underflow_err<=1.
  - NOP or cmd_valid=0: no change; loop_exit=0.
- State UNWIND, cmd_ready=0:
  - Each cycle pops one level, pulses loop_exit, and decrements the counter.
  - Returns to IDLE when the counter reaches 0 or depth reaches 0.
  - If depth hits 0 with the counter still nonzero, underflow_err<=1.
  - Commands are held off: no acceptance, so cmd_valid may stay asserted.
- loop_exit is high for exactly one cycle per popped level. Back-to-back pops give consecutive high cycles.
- Popped entries are zeroed. Entries above depth always read 0.
- Error flags clear only on reset.

Test Plan:
- Reset then PUSH arg=5 indep=0 -> depth=1, lanes=1. Five STEPs -> top_remaining 4,3,2,1. last_iter=1 before the fifth STEP. After it, depth=0 and loop_exit pulses once.
- PUSH arg=10 indep=1 (W=4) -> lanes 4,4,2 across three STEPs. top_remaining 6,2,0. Auto-pop after the third STEP.
- PUSH arg=3, PUSH arg=2 indep=1, STEP -> inner pops (consumes 2). depth=1, top_remaining=3, single loop_exit pulse.
- Fill 8 levels, PUSH again -> overflow_err=1, depth stays 8. BREAK arg=3 -> cmd_ready low 2 cycles. loop_exit high 3 consecutive cycles; depth=5.
- depth=2, BREAK arg=5 -> two pops, underflow_err=1, depth=0, cmd_ready=1 after. STEP on empty keeps underflow_err=1.
- PUSH arg=0 -> depth unchanged, loop_exit pulse. Assert reset mid-UNWIND -> depth=0 immediately (async), flags cleared, cmd_ready=1.
